keyboard_buffer: RTL and testbench

Receive-side character FIFO between the keyboard serial receiver and the CPU's memory-mapped keyboard port. Each completed received byte is queued as a 7-bit ASCII character. The CPU polls `KB_status` to see whether a character is waiting, reads the head character on `KB_data`, and pops it with `KB_read_en`. `buf_full` tells the receiver side that further characters will be dropped.

---
 rtl/kb_pkg.sv | 10 +
 rtl/keyboard_buffer_rise_detect.sv | 27 ++
 rtl/keyboard_buffer.sv | 106 ++++++++++
 tb/tb_keyboard_buffer.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/kb_pkg.sv
// Shared definitions for the keyboard receive buffer: character width,
// default depth and the character type carried through the FIFO.
package kb_pkg;

    localparam int KB_CHAR_W        = 7;
    localparam int KB_DEPTH_DEFAULT = 16;

    typedef logic [KB_CHAR_W-1:0] kb_char_t;

endpackage : kb_pkg

// File: rtl/keyboard_buffer_rise_detect.sv
// Rising-edge detector: turns a level strobe into a single-cycle pulse.
// The pulse is combinational so that the clock edge which first samples the
// level high is the same edge that acts on it.
module rise_detect (
    input  logic clk,
    input  logic rst,
    input  logic level,
    output logic pulse
);

    logic level_q_r;

    // Remember the previous level so a held strobe only fires once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            level_q_r <= 1'b0;
        end else begin
            level_q_r <= level;
        end
    end

    // Pulse is high only in the first cycle the level is seen high.
    always_comb begin
        pulse = level & ~level_q_r;
    end

endmodule : rise_detect

// File: rtl/keyboard_buffer.sv
// Keyboard receive FIFO: queues 7-bit characters from the serial receiver and
// presents the oldest one to the CPU with first-word fall-through.
module keyboard_buffer
    import kb_pkg::*;
#(
    parameter int DEPTH  = KB_DEPTH_DEFAULT,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic       clk,
    input  logic       KB_clear,
    input  logic [7:0] rx_data,
    input  logic       rx_done,
    input  logic       KB_read_en,
    output logic       KB_status,
    output kb_char_t   KB_data,
    output logic       buf_full
);

    localparam logic [ADDR_W-1:0] PTR_ONE    = ADDR_W'(1);
    localparam logic [ADDR_W:0]   CNT_ONE    = (ADDR_W + 1)'(1);
    localparam logic [ADDR_W:0]   CNT_ZERO   = (ADDR_W + 1)'(0);
    localparam logic [ADDR_W:0]   FULL_COUNT = (ADDR_W + 1)'(DEPTH);

    kb_char_t          mem_r [DEPTH];
    logic [ADDR_W-1:0] wr_ptr_r;
    logic [ADDR_W-1:0] rd_ptr_r;
    logic [ADDR_W:0]   count_r;

    logic push_s;
    logic pop_s;
    logic do_push_s;
    logic do_pop_s;
    logic empty_s;
    logic full_s;

    // Bit 7 of the received byte is not part of the ASCII character.
    logic rx_bit7_unused_s;
    assign rx_bit7_unused_s = rx_data[7];

    rise_detect u_push_detect (
        .clk   (clk),
        .rst   (KB_clear),
        .level (rx_done),
        .pulse (push_s)
    );

    rise_detect u_pop_detect (
        .clk   (clk),
        .rst   (KB_clear),
        .level (KB_read_en),
        .pulse (pop_s)
    );

    // Decide which requests take effect: a pop needs data, and a push into a
    // full buffer only succeeds when a pop frees a slot in the same cycle.
    always_comb begin
        empty_s   = (count_r == CNT_ZERO);
        full_s    = (count_r == FULL_COUNT);
        do_pop_s  = pop_s & ~empty_s;
        do_push_s = push_s & (~full_s | do_pop_s);
    end

    // Pointer and occupancy bookkeeping; clear empties the buffer at once.
    always_ff @(posedge clk or posedge KB_clear) begin
        if (KB_clear) begin
            wr_ptr_r <= {ADDR_W{1'b0}};
            rd_ptr_r <= {ADDR_W{1'b0}};
            count_r  <= CNT_ZERO;
        end else begin
            if (do_push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end else begin
                wr_ptr_r <= wr_ptr_r;
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end else begin
                rd_ptr_r <= rd_ptr_r;
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + CNT_ONE;
                2'b01:   count_r <= count_r - CNT_ONE;
                default: count_r <= count_r;
            endcase
        end
    end

    // Character storage; contents are don't-care after clear, so no reset.
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            mem_r[wr_ptr_r] <= rx_data[KB_CHAR_W-1:0];
        end
    end

    // Head character shown with no read latency, forced to zero when empty.
    always_comb begin
        if (empty_s) begin
            KB_data = 7'h00;
        end else begin
            KB_data = mem_r[rd_ptr_r];
        end
        KB_status = ~empty_s;
        buf_full  = full_s;
    end

endmodule : keyboard_buffer

// File: tb/tb_keyboard_buffer.sv
// Self-checking bench for keyboard_buffer. A queue-based model of the
// character FIFO predicts status, head character and full flag each cycle.
module tb_keyboard_buffer;

    localparam int DEPTH = 16;

    logic       clk;
    logic       KB_clear;
    logic [7:0] rx_data;
    logic       rx_done;
    logic       KB_read_en;
    logic       KB_status;
    logic [6:0] KB_data;
    logic       buf_full;

    int n_tests;
    int n_fail;

    logic [6:0] model_q[$];
    logic       m_rxd_prev;
    logic       m_rd_prev;

    keyboard_buffer #(.DEPTH(DEPTH)) dut (
        .clk        (clk),
        .KB_clear   (KB_clear),
        .rx_data    (rx_data),
        .rx_done    (rx_done),
        .KB_read_en (KB_read_en),
        .KB_status  (KB_status),
        .KB_data    (KB_data),
        .buf_full   (buf_full)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic exp_status();
        return model_q.size() != 0;
    endfunction

    function automatic logic [6:0] exp_data();
        if (model_q.size() == 0) return 7'h00;
        return model_q[0];
    endfunction

    function automatic logic exp_full();
        return model_q.size() == DEPTH;
    endfunction

    // Apply one cycle of inputs, update the model, wait past the edge.
    task automatic step(input logic rxd, input logic [7:0] d, input logic rd);
        logic push, pop, popped;
        int   sz;
        push   = rxd && !m_rxd_prev;
        pop    = rd && !m_rd_prev;
        sz     = model_q.size();
        popped = pop && (sz > 0);
        if (popped) void'(model_q.pop_front());
        if (push && (sz < DEPTH || popped)) model_q.push_back(d[6:0]);
        m_rxd_prev = rxd;
        m_rd_prev  = rd;
        rx_done    = rxd;
        rx_data    = d;
        KB_read_en = rd;
        @(posedge clk);
        #1;
    endtask

    task automatic model_clear();
        model_q.delete();
        m_rxd_prev = 1'b0;
        m_rd_prev  = 1'b0;
    endtask

    task automatic test_reset();
        KB_clear   = 1'b1;
        rx_done    = 1'b0;
        rx_data    = 8'h00;
        KB_read_en = 1'b0;
        model_clear();
        @(posedge clk);
        #1;
        KB_clear = 1'b0;
        @(negedge clk);
        n_tests++;
        if ({KB_status, KB_data, buf_full} !== {1'b0, 7'h00, 1'b0}) begin
            n_fail++;
            $display("FAIL reset: got status=%0b data=%h full=%0b, want 0/00/0",
                     KB_status, KB_data, buf_full);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_hello();
        logic [7:0] hello [11] = '{8'h68, 8'h65, 8'h6C, 8'h6C, 8'h6F, 8'h20,
                                   8'h77, 8'h6F, 8'h72, 8'h6C, 8'h64};
        for (int i = 0; i < 11; i++) begin
            step(1'b1, hello[i], 1'b0);
            n_tests++;
            if ({KB_status, KB_data, buf_full} !== {1'b1, 7'h68, 1'b0}) begin
                n_fail++;
                $display("FAIL hello_push[%0d]: got status=%0b data=%h full=%0b, want 1/68/0",
                         i, KB_status, KB_data, buf_full);
            end
            step(1'b0, hello[i], 1'b0);
        end
    endtask

    task automatic test_pop_all();
        logic [6:0] want [11] = '{7'h65, 7'h6C, 7'h6C, 7'h6F, 7'h20, 7'h77,
                                  7'h6F, 7'h72, 7'h6C, 7'h64, 7'h00};
        for (int i = 0; i < 11; i++) begin
            step(1'b0, 8'h00, 1'b1);
            n_tests++;
            if ({KB_status, KB_data} !== {(i != 10), want[i]} ||
                KB_data !== exp_data()) begin
                n_fail++;
                $display("FAIL pop[%0d]: got status=%0b data=%h, want %0b/%h",
                         i, KB_status, KB_data, (i != 10), want[i]);
            end
            step(1'b0, 8'h00, 1'b0);
        end
    endtask

    task automatic test_held();
        for (int i = 0; i < 4; i++) step(1'b1, 8'hE5, 1'b0);
        step(1'b0, 8'h00, 1'b0);
        n_tests++;
        if ({KB_status, KB_data} !== {1'b1, 7'h65} || model_q.size() != 1) begin
            n_fail++;
            $display("FAIL held_push: got status=%0b data=%h, want 1/65", KB_status, KB_data);
        end
        step(1'b1, 8'h41, 1'b0);
        step(1'b0, 8'h41, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b0, 8'h00, 1'b1);
        step(1'b0, 8'h00, 1'b0);
        n_tests++;
        if ({KB_status, KB_data} !== {1'b1, 7'h41}) begin
            n_fail++;
            $display("FAIL held_pop: got status=%0b data=%h, want 1/41", KB_status, KB_data);
        end
        step(1'b0, 8'h00, 1'b1);
        step(1'b0, 8'h00, 1'b0);
        n_tests++;
        if ({KB_status, KB_data} !== {1'b0, 7'h00}) begin
            n_fail++;
            $display("FAIL held_drain: got status=%0b data=%h, want 0/00", KB_status, KB_data);
        end
    endtask

    task automatic test_full();
        logic [6:0] last_seen;
        for (int i = 0; i < DEPTH; i++) begin
            step(1'b1, 8'h30 + 8'(i), 1'b0);
            step(1'b0, 8'h00, 1'b0);
        end
        n_tests++;
        if ({KB_status, KB_data, buf_full} !== {1'b1, 7'h30, 1'b1}) begin
            n_fail++;
            $display("FAIL full_fill: got status=%0b data=%h full=%0b, want 1/30/1",
                     KB_status, KB_data, buf_full);
        end
        step(1'b1, 8'hFA, 1'b0);
        step(1'b0, 8'h00, 1'b0);
        n_tests++;
        if ({KB_data, buf_full} !== {7'h30, 1'b1} || model_q.size() != DEPTH) begin
            n_fail++;
            $display("FAIL full_drop: got data=%h full=%0b, want 30/1", KB_data, buf_full);
        end
        step(1'b1, 8'h55, 1'b1);
        n_tests++;
        if ({KB_data, buf_full} !== {7'h31, 1'b1}) begin
            n_fail++;
            $display("FAIL full_simul: got data=%h full=%0b, want 31/1", KB_data, buf_full);
        end
        step(1'b0, 8'h00, 1'b0);
        last_seen = 7'h00;
        for (int i = 0; i < DEPTH; i++) begin
            last_seen = KB_data;
            step(1'b0, 8'h00, 1'b1);
            n_tests++;
            if ({KB_status, KB_data, buf_full} !== {exp_status(), exp_data(), exp_full()}) begin
                n_fail++;
                $display("FAIL full_drain[%0d]: got %0b/%h/%0b, want %0b/%h/%0b", i,
                         KB_status, KB_data, buf_full, exp_status(), exp_data(), exp_full());
            end
            step(1'b0, 8'h00, 1'b0);
        end
        n_tests++;
        if (last_seen !== 7'h55 || KB_status !== 1'b0) begin
            n_fail++;
            $display("FAIL full_tail: got last=%h status=%0b, want 55/0", last_seen, KB_status);
        end
    endtask

    task automatic test_clear();
        step(1'b1, 8'h65, 1'b0);
        step(1'b0, 8'h00, 1'b0);
        n_tests++;
        if ({KB_status, KB_data} !== {1'b1, 7'h65}) begin
            n_fail++;
            $display("FAIL clear_pre: got status=%0b data=%h, want 1/65", KB_status, KB_data);
        end
        #2;
        KB_clear = 1'b1;
        #1;
        n_tests++;
        if ({KB_status, KB_data, buf_full} !== {1'b0, 7'h00, 1'b0}) begin
            n_fail++;
            $display("FAIL clear_async: got status=%0b data=%h full=%0b, want 0/00/0",
                     KB_status, KB_data, buf_full);
        end
        #1;
        KB_clear = 1'b0;
        model_clear();
        step(1'b1, 8'h42, 1'b0);
        n_tests++;
        if ({KB_status, KB_data} !== {1'b1, 7'h42}) begin
            n_fail++;
            $display("FAIL clear_repush: got status=%0b data=%h, want 1/42", KB_status, KB_data);
        end
        step(1'b0, 8'h00, 1'b0);
    endtask

    task automatic test_random();
        logic       rxd, rd;
        logic [7:0] d;
        for (int i = 0; i < 400; i++) begin
            rxd = ($urandom_range(0, 99) < 55);
            rd  = ($urandom_range(0, 99) < 35);
            d   = 8'($urandom);
            if (rxd && m_rxd_prev) d = rx_data;
            step(rxd, d, rd);
            n_tests++;
            if ({KB_status, KB_data, buf_full} !== {exp_status(), exp_data(), exp_full()}) begin
                n_fail++;
                $display("FAIL random[%0d]: got %0b/%h/%0b, want %0b/%h/%0b", i,
                         KB_status, KB_data, buf_full, exp_status(), exp_data(), exp_full());
            end
        end
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        test_reset();
        test_hello();
        test_pop_all();
        test_held();
        test_full();
        test_clear();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_keyboard_buffer
